// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter: 8-channel request capture with a registered one-hot grant and 3-bit code under valid/ready.
// ARB_ROUND_ROBIN_EN selects pointer-based round-robin; undefined gives fixed priority (7 highest).
module req_onehot_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] grant,
    output logic [2:0] code,
    output logic       busy
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d, grant_q, grant_d, clr;
    logic [2:0] code_q, code_d, sel;
    logic       valid_q, valid_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d, idx;
    // Walk downward so the set bit nearest to ptr is the last to land in sel.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr_q + 3'(i);
            if (pending_q[idx]) sel = idx;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < 8; i++)
            if (pending_q[i]) sel = 3'(i);
    end
`endif
    always_comb begin
        clr       = (valid_q && ready) ? grant_q : '0;
        pending_d = (pending_q & ~clr) | req;
        state_d   = state_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        code_d    = code_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        if (state_q == IDLE && pending_q != '0) begin
            state_d = OFFER;
            valid_d = 1'b1;
            grant_d = 8'b1 << sel;
            code_d  = sel;
        end else if (state_q == OFFER && ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
            code_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d   = code_q + 3'd1;
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            code_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            code_q    <= code_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end
    assign valid = valid_q;
    assign grant = grant_q;
    assign code  = code_q;
    assign busy  = |pending_q;
endmodule

// File: tb/tb_req_onehot_arbiter.sv
// tb_req_onehot_arbiter: directed and random checks of req_onehot_arbiter against a channel-level model.
module tb_req_onehot_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       ready = 1'b0;
    logic       valid, busy;
    logic [7:0] grant;
    logic [2:0] code;
    int total = 0;
    int bad = 0;

    req_onehot_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .valid(valid), .grant(grant), .code(code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: set of pending channels, whether a channel is on offer, which one, and the rotation start.
    bit m_pend[8];
    bit m_offer;
    int m_ch;
    int m_ptr;

    function automatic bit m_any();
        for (int i = 0; i < 8; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 8; k++) if (m_pend[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
`else
        for (int c = 7; c >= 0; c--) if (m_pend[c]) return c;
`endif
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_offer = 1'b0;
            m_ch = 0;
            m_ptr = 0;
        end else begin
            if (m_offer) begin
                if (ready) begin
                    m_pend[m_ch] = 1'b0;
                    m_ptr = (m_ch + 1) % 8;
                    m_offer = 1'b0;
                end
            end else if (m_any()) begin
                m_ch = m_pick();
                m_offer = 1'b1;
            end
            for (int i = 0; i < 8; i++) if (req[i]) m_pend[i] = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 32'(valid), 32'(m_offer));
        chk("m_grant", 32'(grant), m_offer ? (32'd1 << m_ch) : 32'd0);
        chk("m_code", 32'(code), m_offer ? 32'(m_ch) : 32'd0);
        chk("m_busy", 32'(busy), 32'(m_any()));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!valid && n < lim) begin
            cyc();
            n++;
        end
        chk("wait_valid", 32'(valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        ready = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int codes[4];
        int got;
        int n;
        do_reset();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);

        req = 8'h08; ready = 1'b1;
        cyc();
        chk("single_busy", 32'(busy), 1);
        chk("single_early", 32'(valid), 0);
        req = '0;
        cyc();
        chk("single_valid", 32'(valid), 1);
        chk("single_grant", 32'(grant), 32'h08);
        chk("single_code", 32'(code), 3);
        cyc();
        chk("single_drop", 32'(valid), 0);
        chk("single_idle", 32'(busy), 0);

        req = 8'h40; ready = 1'b0;
        cyc();
        req = '0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_grant", 32'(grant), 32'h40);
            chk("bp_code", 32'(code), 6);
            cyc();
        end
        ready = 1'b1;
        cyc();
        chk("bp_drop", 32'(valid), 0);
        chk("bp_clear", 32'(busy), 0);

        do_reset();
        req = 8'h81; ready = 1'b1;
        got = 0; n = 0;
        while (got < 4 && n < 40) begin
            cyc();
            if (valid) begin
                codes[got] = int'(code);
                got++;
            end
            n++;
        end
        chk("arb_count", 32'(got), 4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("rr_0", 32'(codes[0]), 0);
        chk("rr_1", 32'(codes[1]), 7);
        chk("rr_2", 32'(codes[2]), 0);
        chk("rr_3", 32'(codes[3]), 7);
`else
        for (int i = 0; i < 4; i++) chk("fp_code", 32'(codes[i]), 7);
`endif
        n = 0;
        while (!(valid && grant == 8'h80) && n < 20) begin
            cyc();
            n++;
        end
        chk("drop7_wait", 32'(grant), 32'h80);
        req = 8'h01;
        cyc();
        cyc();
        chk("drop7_valid", 32'(valid), 1);
        chk("drop7_code", 32'(code), 0);
        req = '0;
        repeat (3) cyc();

        ready = 1'b0; req = 8'h04;
        cyc();
        req = '0;
        wait_valid(10);
        chk("col_grant", 32'(grant), 32'h04);
        req = 8'h04; ready = 1'b1;
        cyc();
        chk("col_busy", 32'(busy), 1);
        chk("col_gap", 32'(valid), 0);
        req = '0;
        cyc();
        chk("col_again", 32'(grant), 32'h04);
        cyc();
        chk("col_done", 32'(busy), 0);

        ready = 1'b0; req = 8'h20;
        cyc();
        req = '0;
        cyc();
        chk("mid_grant", 32'(grant), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(valid), 0);
        chk("mid_grant0", 32'(grant), 0);
        chk("mid_code", 32'(code), 0);
        chk("mid_busy", 32'(busy), 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst", 32'(valid), 0);
        end

        for (int i = 0; i < 600; i++) begin
            req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ready = 1'($urandom_range(0, 1));
            cyc();
        end
        req = '0; ready = 1'b1;
        repeat (20) cyc();
        chk("drain_busy", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/req_onehot_arbiter.md
# req_onehot_arbiter

Eight-channel request capture and arbitration stage that sits directly upstream of the 8-to-3 encoder. It latches request pulses into a pending register and selects exactly one pending channel at a time. It presents that channel as a registered one-hot grant, guaranteeing the encoder never sees more than one active line, together with its 3-bit code under a valid/ready handshake. A granted channel's pending bit is cleared only when the consumer accepts it.

## Interface
- No parameters; channel count fixed at 8, code width fixed at 3.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  per-channel request; sampled every rising edge, level or pulse
- ready  input  1  consumer accepts current grant when high with valid
- valid  output  1  grant/code hold a selected channel
- grant  output  8  one-hot selected channel; all zero when valid=0
- code  output  3  binary index of grant; 0 when valid=0
- busy  output  1  OR of pending register (combinational from the register)

## Operation
- pending[7:0]: each edge, pending <= (pending & ~clr) | req. clr is the one-hot grant when valid&&ready, else 0. A set and a clear on the same bit in the same edge: set wins, and the bit stays pending.
- A request on an already-pending bit merges; there is no count and no error.
- FSM, two states:
  - IDLE: valid=0, grant=0, code=0. If pending!=0 at an edge, select one channel from the registered pending value, load grant/code, set valid=1, go to OFFER. Otherwise stay.
  - OFFER: grant/code/valid held stable while ready=0. On an edge with ready=1, clear the granted pending bit, update the pointer, return to IDLE with valid=0.
- Selection (round-robin, see Configuration):
  - 3-bit pointer ptr, reset 0.
  - Search pending from index ptr upward, wrapping 7 to 0.
  - The first set bit wins.
  - On acceptance, ptr <= code+1, with 7 wrapping to 0.
- Selection considers only pending bits; req arriving on the same edge is not visible until the next edge.
- grant is always one-hot or zero, and code always equals the index of grant.

## Timing
- Reset (asynchronous assert, synchronous release by design): pending=0, ptr=0, state IDLE, valid=0, grant=0, code=0, busy=0. Outputs clear immediately on rst_n low, including mid-OFFER; the in-flight grant is discarded.
- Latency:
  - req high before edge k sets pending after edge k, and busy goes high in that cycle.
  - valid rises after edge k+1.
- Acceptance at edge m drops valid after m. The earliest next valid is after edge m+1. There is one bubble cycle, so maximum throughput is one grant per 2 cycles.
- ready while valid=0 is ignored.
- A continuously asserted req on a granted channel re-pends it. Round-robin still services the other channels before returning to it.

## Configuration
- ARB_ROUND_ROBIN_EN defined: pointer-based round-robin as above.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the highest set index wins (7 highest).
  - ptr is not implemented and is not updated.
  - Low channels can starve.

## Test plan
- Reset: assert rst_n=0 mid-OFFER with grant=8'h20 -> valid=0, grant=0, code=0, busy=0 immediately; after release, no grant appears without new req.
- Single request: pulse req=8'h08 for one cycle, ready=1 -> busy high 1 cycle later, valid with grant=8'h08, code=3 two cycles after req, valid low the cycle after acceptance, busy=0.
- Backpressure: req=8'h40, ready=0 for 5 cycles -> grant=8'h40, code=6 stable for all 5 cycles; raise ready -> one acceptance, pending bit 6 cleared.
- Round-robin (macro on): pulse req=8'h81 once, ready=1 -> grants in order code 0 then code 7, ptr after the second acceptance is 0. Hold req=8'h81 continuously -> codes alternate 0,7,0,7.
- Fixed priority (macro off): req=8'h81 held -> code 7 every grant, channel 0 never granted. Drop req[7] -> next grant code 0.
- Set/clear collision: req[2] asserted on the same edge that accepts grant 8'h04 -> pending[2] remains 1, busy stays 1, channel 2 is offered again.
